cortisol_monitor: RTL

- Reader/consumer side of the 2-bit downscaled cortisol level produced by the cortisol system.
- Debounces the level, then tracks a stress-response state machine: CALM, ALERT, STRESSED, EXHAUSTED.
- Emits event pulses and a negative-feedback request (HPA-axis style) that the cortisol regulator ORs into its dec input.
- Sits between the neurotransmitter block and the emotional-state/action logic.

---
 rtl/stress_pkg.sv | 14 +
 rtl/cortisol_monitor_if.sv | 29 ++
 rtl/cortisol_monitor_level_debouncer.sv | 50 +++++
 rtl/cortisol_monitor.sv | 132 +++++++++++++
 4 files changed

// File: rtl/stress_pkg.sv
// Shared encodings and widths for the stress-response monitor.
package stress_pkg;

    localparam int unsigned STRESS_CNT_W = 6;
    localparam int unsigned LEVEL_W      = 2;

    typedef enum logic [1:0] {
        ST_CALM      = 2'd0,
        ST_ALERT     = 2'd1,
        ST_STRESSED  = 2'd2,
        ST_EXHAUSTED = 2'd3
    } stress_state_t;

endpackage

// File: rtl/cortisol_monitor_if.sv
// Sample input and status/event outputs of the cortisol monitor.
interface cortisol_monitor_if;

    logic       tick;
    logic [1:0] cortisol_level;
    logic [1:0] stress_state;
    logic       stress_onset;
    logic       recovered;
    logic       feedback_dec;

    modport master (
        output tick,
        output cortisol_level,
        input  stress_state,
        input  stress_onset,
        input  recovered,
        input  feedback_dec
    );

    modport slave (
        input  tick,
        input  cortisol_level,
        output stress_state,
        output stress_onset,
        output recovered,
        output feedback_dec
    );

endinterface

// File: rtl/cortisol_monitor_level_debouncer.sv
// Level debouncer: output follows the input once it has been stable for DWELL ticks.
module level_debouncer #(
    parameter int unsigned N     = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    localparam int unsigned CNT_W = 3;

    if (DWELL == 0 || DWELL > 7) begin : g_bad_dwell
        $error("level_debouncer: DWELL must be in 1..7");
    end

    logic [N-1:0]     cand;
    logic [N-1:0]     filt_level;
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] stab_nxt;

    // A new candidate restarts the run at 1; an equal sample extends it up to DWELL.
    always_comb begin
        stab_nxt = stab_cnt;
        if (din != cand) begin
            stab_nxt = CNT_W'(1);
        end else if (stab_cnt != CNT_W'(DWELL)) begin
            stab_nxt = stab_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand       <= '0;
            stab_cnt   <= '0;
            filt_level <= '0;
        end else if (tick) begin
            cand     <= din;
            stab_cnt <= stab_nxt;
            if (stab_nxt == CNT_W'(DWELL)) begin
                filt_level <= din;
            end
        end
    end

    assign dout = filt_level;

endmodule

// File: rtl/cortisol_monitor.sv
// Stress-response tracker on the debounced cortisol level.
// Optional fatigue path (EXHAUSTED state, dwell counters, recovered pulse): CORTISOL_MONITOR_FATIGUE_EN.
module cortisol_monitor
    import stress_pkg::*;
#(
    parameter int unsigned DWELL         = 4,
    parameter int unsigned EXHAUST_TICKS = 32,
    parameter int unsigned RECOVER_TICKS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    cortisol_monitor_if.slave  bus
);

    if (EXHAUST_TICKS == 0 || EXHAUST_TICKS > 63) begin : g_bad_exhaust
        $error("cortisol_monitor: EXHAUST_TICKS must be in 1..63");
    end
    if (RECOVER_TICKS == 0 || RECOVER_TICKS > 63) begin : g_bad_recover
        $error("cortisol_monitor: RECOVER_TICKS must be in 1..63");
    end

    logic [LEVEL_W-1:0] filt;
    stress_state_t      state;
    logic               stress_onset_q;
    logic               feedback_dec_q;

    level_debouncer #(
        .N     (LEVEL_W),
        .DWELL (DWELL)
    ) u_debouncer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (bus.tick),
        .din   (bus.cortisol_level),
        .dout  (filt)
    );

`ifdef CORTISOL_MONITOR_FATIGUE_EN
    logic [STRESS_CNT_W-1:0] exh_cnt;
    logic [STRESS_CNT_W-1:0] rec_cnt;
    logic                    recovered_q;
`endif

    // FSM steps on the pre-edge filtered level; feedback_dec tracks the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_CALM;
            stress_onset_q <= 1'b0;
            feedback_dec_q <= 1'b0;
`ifdef CORTISOL_MONITOR_FATIGUE_EN
            exh_cnt        <= '0;
            rec_cnt        <= '0;
            recovered_q    <= 1'b0;
`endif
        end else begin
            stress_onset_q <= 1'b0;
`ifdef CORTISOL_MONITOR_FATIGUE_EN
            recovered_q    <= 1'b0;
`endif
            if (bus.tick) begin
                case (state)
                    ST_CALM: begin
                        if (filt >= 2'd2) begin
                            state          <= ST_STRESSED;
                            stress_onset_q <= 1'b1;
                            feedback_dec_q <= 1'b1;
                        end else if (filt == 2'd1) begin
                            state <= ST_ALERT;
                        end
                    end
                    ST_ALERT: begin
                        if (filt >= 2'd2) begin
                            state          <= ST_STRESSED;
                            stress_onset_q <= 1'b1;
                            feedback_dec_q <= 1'b1;
                        end else if (filt == 2'd0) begin
                            state <= ST_CALM;
                        end
                    end
                    ST_STRESSED: begin
                        if (filt <= 2'd1) begin
                            state          <= ST_ALERT;
                            feedback_dec_q <= 1'b0;
`ifdef CORTISOL_MONITOR_FATIGUE_EN
                            exh_cnt        <= '0;
                        end else if (filt == 2'd3) begin
                            if (exh_cnt + STRESS_CNT_W'(1) == STRESS_CNT_W'(EXHAUST_TICKS)) begin
                                state   <= ST_EXHAUSTED;
                                exh_cnt <= '0;
                            end else begin
                                exh_cnt <= exh_cnt + STRESS_CNT_W'(1);
                            end
                        end else begin
                            exh_cnt <= '0;
`endif
                        end
                    end
`ifdef CORTISOL_MONITOR_FATIGUE_EN
                    ST_EXHAUSTED: begin
                        if (filt == 2'd0) begin
                            if (rec_cnt + STRESS_CNT_W'(1) == STRESS_CNT_W'(RECOVER_TICKS)) begin
                                state          <= ST_CALM;
                                rec_cnt        <= '0;
                                recovered_q    <= 1'b1;
                                feedback_dec_q <= 1'b0;
                            end else begin
                                rec_cnt <= rec_cnt + STRESS_CNT_W'(1);
                            end
                        end else begin
                            rec_cnt <= '0;
                        end
                    end
`endif
                    default: begin
                        state          <= ST_CALM;
                        feedback_dec_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.stress_state = state;
    assign bus.stress_onset = stress_onset_q;
    assign bus.feedback_dec = feedback_dec_q;
`ifdef CORTISOL_MONITOR_FATIGUE_EN
    assign bus.recovered    = recovered_q;
`else
    assign bus.recovered    = 1'b0;
`endif

endmodule
